// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words from imem over req/ack, hands them to decode over valid/ready.
// Latency: imem_req one cycle after reset release; instr_valid the cycle after ack; next request the cycle after a transfer.
// Backpressure: holds instr/instr_pc stable and stops fetching while decode is not ready; imem_req/addr stay fixed until ack.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   branch, branch_en, jump, target redirect request from branch decoder / execute
//   imem_req, imem_addr             fetch request towards instruction memory
//   imem_ack, imem_rdata            fetch completion and returned word
//   instr_valid, instr_ready        handshake towards decode
//   instr, instr_pc                 fetched word and its address
//   misalign_trap                   one-cycle pulse on a misaligned redirect target
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap (and halt) on redirects
// whose target[1:0] != 0. Without it the low target bits are forced to 00.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic        branch_en,
  input  logic        jump,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_trap
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_HOLD,
    S_DROP,
    S_HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_START,
    S_FETCH,
    S_HOLD,
    S_DROP
  } state_t;
`endif

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] saved_tgt_q;   // redirect target remembered while a wrong-path fetch drains
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic        instr_valid_q;
  logic        trap_q;

  logic        redirect;
  logic [31:0] tgt_eff;
  logic [31:0] pc_inc_d;
  logic [31:0] drop_tgt_d;    // target to resume from when the draining fetch completes
  logic        tgt_mis;
  logic        drop_mis;

  assign redirect   = (branch_en & branch) | jump;
  assign pc_inc_d   = pc_q + 32'd4;   // wraps modulo 2^32 by construction

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt_eff    = target;
  assign tgt_mis    = target[1:0] != 2'b00;
`else
  logic unused_tgt_low;
  assign unused_tgt_low = ^target[1:0];
  assign tgt_eff    = {target[31:2], 2'b00};
  assign tgt_mis    = 1'b0;
`endif

  // The latest redirect wins, including one arriving in the same cycle as the ack.
  assign drop_tgt_d = redirect ? tgt_eff : saved_tgt_q;
  assign drop_mis   = drop_tgt_d[1:0] != 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_START;
      pc_q          <= RESET_PC;
      saved_tgt_q   <= RESET_PC;
      instr_q       <= NOP;
      instr_pc_q    <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      case (state_q)
        S_START: begin
          state_q     <= S_FETCH;
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_q;
        end

        S_FETCH: begin
          if (redirect && imem_ack) begin
            // Returned word is wrong-path; refetch from the target right away.
            if (tgt_mis) begin
`ifdef FETCH_MISALIGN_TRAP_EN
              pc_q       <= tgt_eff;
              instr_pc_q <= tgt_eff;
              imem_req_q <= 1'b0;
              trap_q     <= 1'b1;
              state_q    <= S_HALT;
`endif
            end else begin
              pc_q        <= tgt_eff;
              imem_addr_q <= tgt_eff;
            end
          end else if (redirect) begin
            // Request must stay stable until ack, so drain it in DROP.
            saved_tgt_q <= tgt_eff;
            state_q     <= S_DROP;
          end else if (imem_ack) begin
            instr_q       <= imem_rdata;
            instr_pc_q    <= pc_q;
            pc_q          <= pc_inc_d;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            // A same-cycle transfer still completes; decode squashes it itself.
            instr_valid_q <= 1'b0;
            if (tgt_mis) begin
`ifdef FETCH_MISALIGN_TRAP_EN
              pc_q       <= tgt_eff;
              instr_pc_q <= tgt_eff;
              trap_q     <= 1'b1;
              state_q    <= S_HALT;
`endif
            end else begin
              pc_q        <= tgt_eff;
              imem_addr_q <= tgt_eff;
              imem_req_q  <= 1'b1;
              state_q     <= S_FETCH;
            end
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
            imem_addr_q   <= pc_q;
            imem_req_q    <= 1'b1;
            state_q       <= S_FETCH;
          end
        end

        S_DROP: begin
          if (redirect) begin
            saved_tgt_q <= tgt_eff;
          end
          if (imem_ack) begin
            if (drop_mis) begin
`ifdef FETCH_MISALIGN_TRAP_EN
              pc_q       <= drop_tgt_d;
              instr_pc_q <= drop_tgt_d;
              imem_req_q <= 1'b0;
              trap_q     <= 1'b1;
              state_q    <= S_HALT;
`endif
            end else begin
              pc_q        <= drop_tgt_d;
              imem_addr_q <= drop_tgt_d;
              state_q     <= S_FETCH;
            end
          end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        S_HALT: begin
          // Only rst leaves this state.
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
`endif

        default: begin
          state_q       <= S_START;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = imem_addr_q;
  assign instr_valid   = instr_valid_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap   = trap_q;
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with RESET_PC = 0x100.
// Memory returns addr ^ KEY combinationally when ack_en is set.
// Inputs driven and outputs sampled on the falling clock edge.

module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        branch;
  logic        branch_en;
  logic        jump;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_trap;
  logic        ack_en;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch       (branch),
    .branch_en    (branch_en),
    .jump         (jump),
    .target       (target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .misalign_trap(misalign_trap)
  );

  assign imem_ack   = ack_en;
  assign imem_rdata = imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; branch = 1'b0; branch_en = 1'b0; jump = 1'b0;
    target = 32'h0; ack_en = 1'b0; instr_ready = 1'b0;
    #2;
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, RPC);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc",    instr_pc, RPC);
    chk("rst_trap",  {31'b0, misalign_trap}, 32'h0);

    tick(); rst = 1'b0;
    #1 chk("req_low_at_release", {31'b0, imem_req}, 32'h0);
    tick();
    chk("first_req",  {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, RPC);
    ack_en = 1'b1; instr_ready = 1'b1;

    // Zero-wait stream: 0x100, 0x104, 0x108 at one instruction per two cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_valid", {31'b0, instr_valid}, 32'h1);
      chk("seq_pc",    instr_pc, RPC + 32'(4 * i));
      chk("seq_instr", instr, (RPC + 32'(4 * i)) ^ KEY);
      if (i == 2) instr_ready = 1'b0;
      else begin
        tick();
        chk("seq_addr", imem_addr, RPC + 32'(4 * (i + 1)));
      end
    end

    // Decode stalls for 5 cycles: everything holds, no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_pc",    instr_pc, 32'h108);
      chk("stall_req",   {31'b0, imem_req}, 32'h0);
    end
    instr_ready = 1'b1;
    tick();
    chk("after_stall_req",  {31'b0, imem_req}, 32'h1);
    chk("after_stall_addr", imem_addr, 32'h10C);
    tick();
    chk("hold_10c", instr_pc, 32'h10C);

    // Not-taken branch: no redirect.
    instr_ready = 1'b0; branch_en = 1'b1; branch = 1'b0; target = 32'h200;
    tick();
    chk("nt_valid", {31'b0, instr_valid}, 32'h1);
    chk("nt_pc",    instr_pc, 32'h10C);
    chk("nt_req",   {31'b0, imem_req}, 32'h0);

    // Taken branch in HOLD.
    branch = 1'b1;
    tick();
    branch = 1'b0; branch_en = 1'b0;
    chk("tk_valid", {31'b0, instr_valid}, 32'h0);
    chk("tk_req",   {31'b0, imem_req}, 32'h1);
    chk("tk_addr",  imem_addr, 32'h200);
    tick();
    chk("tk_pc",    instr_pc, 32'h200);
    chk("tk_instr", instr, 32'h200 ^ KEY);
    instr_ready = 1'b1; ack_en = 1'b0;

    // Jump while a fetch of 0x204 waits for ack.
    tick();
    chk("wait_addr", imem_addr, 32'h204);
    jump = 1'b1; target = 32'h300;
    tick();
    jump = 1'b0;
    chk("drop_addr0", imem_addr, 32'h204);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("drop_req",  {31'b0, imem_req}, 32'h1);
      chk("drop_addr", imem_addr, 32'h204);
    end
    ack_en = 1'b1;
    tick();
    chk("jmp_addr",  imem_addr, 32'h300);
    chk("jmp_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("jmp_pc",    instr_pc, 32'h300);
    chk("jmp_instr", instr, 32'h300 ^ KEY);
    ack_en = 1'b0;

    // Two redirects during one DROP: the later one wins.
    tick();
    chk("dd_addr", imem_addr, 32'h304);
    jump = 1'b1; target = 32'h400;
    tick();
    target = 32'h500;
    tick();
    jump = 1'b0; ack_en = 1'b1;
    chk("dd_hold_addr", imem_addr, 32'h304);
    chk("dd_valid",     {31'b0, instr_valid}, 32'h0);
    tick();
    chk("dd_addr_500", imem_addr, 32'h500);
    tick();
    chk("dd_pc_500", instr_pc, 32'h500);

    // Redirect in the same cycle as ack in FETCH.
    tick();
    chk("sc_addr", imem_addr, 32'h504);
    jump = 1'b1; target = 32'h600;
    tick();
    jump = 1'b0;
    chk("sc_req",   {31'b0, imem_req}, 32'h1);
    chk("sc_addr2", imem_addr, 32'h600);
    chk("sc_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("sc_pc", instr_pc, 32'h600);

    // Redirect with simultaneous transfer, then PC wrap past 0xFFFF_FFFC.
    jump = 1'b1; target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    chk("wr_addr",  imem_addr, 32'hFFFF_FFFC);
    chk("wr_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("wr_pc",    instr_pc, 32'hFFFF_FFFC);
    chk("wr_instr", instr, 32'hFFFF_FFFC ^ KEY);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    tick();
    chk("wrap_pc", instr_pc, 32'h0);

    // Misaligned redirect target.
    branch_en = 1'b1; branch = 1'b1; target = 32'h202;
    tick();
    branch_en = 1'b0; branch = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_trap",  {31'b0, misalign_trap}, 32'h1);
    chk("mis_req",   {31'b0, imem_req}, 32'h0);
    chk("mis_valid", {31'b0, instr_valid}, 32'h0);
    chk("mis_pc",    instr_pc, 32'h202);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_trap", {31'b0, misalign_trap}, 32'h0);
      chk("halt_req",  {31'b0, imem_req}, 32'h0);
    end
`else
    chk("mis_trap", {31'b0, misalign_trap}, 32'h0);
    chk("mis_req",  {31'b0, imem_req}, 32'h1);
    chk("mis_addr", imem_addr, 32'h200);
    tick();
    chk("mis_pc", instr_pc, 32'h200);
`endif

    // Asynchronous reset mid-operation.
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_req",   {31'b0, imem_req}, 32'h0);
    chk("mid_rst_addr",  imem_addr, RPC);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("mid_rst_instr", instr, 32'h0000_0013);
    tick();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
